// File: rtl/mem_bank_arbiter_pkg.sv
// mem_bank_arbiter_pkg: bank geometry, requester ids and one-hot helper
package mem_bank_arbiter_pkg;
  localparam int DEPTH = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 20;
  localparam int NREQ = 2;
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA = 1'b1;
  function automatic logic [NREQ-1:0] onehot(input logic id);
    return {id, ~id};
  endfunction
endpackage

// File: rtl/mem_bank_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick
module rr_arb2
  import mem_bank_arbiter_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last,
  output logic       win_valid,
  output logic       win_id
);
  always_comb begin
    win_valid = |eligible;
    win_id = &eligible ? ~last : (eligible[REQ_DATA] ? REQ_DATA : REQ_FETCH);
  end
endmodule

// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter: round-robin two-requester access controller for the 64x20 bank
module mem_bank_arbiter
  import mem_bank_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata
);
  logic [NREQ-1:0] eligible;
  logic win_valid;
  logic win_id;
  logic last;
  logic pending_rd;
  logic pending_id;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  // a requester accepted this cycle still shows req; masking by gnt avoids a double accept
  always_comb begin
    eligible = req & ~gnt;
    win_addr = win_id ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    win_wdata = win_id ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
  end
  rr_arb2 u_arb (
    .eligible(eligible),
    .last(last),
    .win_valid(win_valid),
    .win_id(win_id)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt <= '0;
      rvalid <= '0;
      rdata <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      last <= 1'b1;
      pending_rd <= 1'b0;
      pending_id <= 1'b0;
    end else begin
      gnt <= win_valid ? onehot(win_id) : '0;
      mem_we <= win_valid && we[win_id];
      pending_rd <= win_valid && !we[win_id];
      rvalid <= pending_rd ? onehot(pending_id) : '0;
      if (pending_rd) rdata <= mem_rdata;
      if (win_valid) begin
        mem_addr <= win_addr;
        mem_wdata <= win_wdata;
        last <= win_id;
        pending_id <= win_id;
      end
    end
  end
endmodule

// File: tb/tb_mem_bank_arbiter.sv
// tb_mem_bank_arbiter: directed and random checks against a cycle-level transaction model
module tb_mem_bank_arbiter;
  import mem_bank_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b1;
  logic [1:0] req = '0;
  logic [1:0] we = '0;
  logic [2*ADDR_W-1:0] addr = '0;
  logic [2*DATA_W-1:0] wdata = '0;
  logic [1:0] gnt;
  logic [1:0] rvalid;
  logic [DATA_W-1:0] rdata;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] bank [DEPTH];
  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int m_last = 1;
  logic [1:0] m_gnt = '0;
  bit acc_v = 0;
  bit acc_we = 0;
  int acc_id = 0;
  int acc_addr = 0;
  logic [DATA_W-1:0] acc_data = '0;
  logic [1:0] exp_rv = '0;
  logic [DATA_W-1:0] exp_rd = '0;
  logic [ADDR_W-1:0] exp_ma = '0;
  logic [DATA_W-1:0] exp_mw = '0;

  always #5 clk = ~clk;

  // bank and read mux live outside the DUT
  assign mem_rdata = bank[mem_addr];
  always @(posedge clk)
    if (clr) for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    else if (mem_we) bank[mem_addr] <= mem_wdata;

  mem_bank_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; model the transaction completing and the next arbitration, then compare
  task automatic cycle();
    bit rs;
    int w;
    logic [1:0] elig;
    rs = rst_n;
    elig = req & ~m_gnt;
    @(posedge clk);
    #1;
    exp_rv = '0;
    if (acc_v && acc_we) ref_mem[acc_addr] = acc_data;
    if (acc_v && !acc_we && rs) begin
      exp_rv[acc_id] = 1'b1;
      exp_rd = ref_mem[acc_addr];
    end
    m_gnt = '0;
    acc_v = 0;
    if (!rs) begin
      exp_rd = '0;
      exp_ma = '0;
      exp_mw = '0;
      m_last = 1;
    end else if (elig != 2'b00) begin
      w = (elig == 2'b11) ? 1 - m_last : (elig[1] ? 1 : 0);
      acc_v = 1;
      m_gnt[w] = 1'b1;
      m_last = w;
      acc_id = w;
      acc_we = we[w];
      acc_addr = int'(addr[w*ADDR_W +: ADDR_W]);
      acc_data = wdata[w*DATA_W +: DATA_W];
      exp_ma = addr[w*ADDR_W +: ADDR_W];
      exp_mw = acc_data;
    end
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("mem_we", 32'(mem_we), 32'(acc_v && acc_we));
    chk("mem_addr", 32'(mem_addr), 32'(exp_ma));
    chk("mem_wdata", 32'(mem_wdata), 32'(exp_mw));
    chk("rvalid", 32'(rvalid), 32'(exp_rv));
    chk("rdata", 32'(rdata), 32'(exp_rd));
  endtask

  task automatic issue(input int k, input bit w, input int a, input logic [DATA_W-1:0] d);
    req[k] = 1'b1;
    we[k] = w;
    addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wdata[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int ng;
    int nr;
    int bnd [4];
    logic [DATA_W-1:0] bval [4];
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    cycle();
    clr = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_rdata", 32'(rdata), 32'h0);

    issue(0, 1, 5, 20'hABCDE);
    cycle();
    chk("t1_gnt_n1", 32'(gnt), 32'h1);
    chk("t1_we_n1", 32'(mem_we), 32'h1);
    issue(0, 0, 5, 20'h0);
    cycle();
    chk("t1_gnt_n2", 32'(gnt), 32'h0);
    cycle();
    chk("t1_gnt_n3", 32'(gnt), 32'h1);
    chk("t1_we_n3", 32'(mem_we), 32'h0);
    req[0] = 1'b0;
    cycle();
    chk("t1_rvalid", 32'(rvalid), 32'h1);
    chk("t1_rdata", 32'(rdata), 32'hABCDE);

    issue(0, 1, 10, 20'h11111);
    issue(1, 1, 20, 20'h22222);
    cycle();
    cycle();
    req = '0;
    cycle();
    do_reset();
    issue(0, 0, 10, 20'h0);
    issue(1, 0, 20, 20'h0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t2_alt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (rvalid == 2'b01) chk("t2_rd0", 32'(rdata), 32'h11111);
      if (rvalid == 2'b10) chk("t2_rd1", 32'(rdata), 32'h22222);
    end
    req = '0;
    cycle();
    cycle();

    issue(1, 1, 63, 20'h0F0F0);
    cycle();
    req[1] = 1'b0;
    issue(0, 0, 63, 20'h0);
    cycle();
    req[0] = 1'b0;
    cycle();
    chk("t3_rvalid", 32'(rvalid), 32'h1);
    chk("t3_rdata", 32'(rdata), 32'h0F0F0);

    ng = 0;
    nr = 0;
    issue(1, 0, 0, 20'h0);
    for (int i = 0; i < 8; i++) begin
      if (i == 6) req[1] = 1'b0;
      cycle();
      ng += int'(gnt[1]);
      nr += int'(rvalid[1]);
    end
    chk("t4_grants", 32'(ng), 32'd3);
    chk("t4_rvalids", 32'(nr), 32'd3);

    issue(0, 1, 7, 20'h00077);
    cycle();
    do_reset();
    chk("t5_rst_gnt", 32'(gnt), 32'h0);
    chk("t5_rst_we", 32'(mem_we), 32'h0);
    issue(0, 0, 7, 20'h0);
    cycle();
    req[0] = 1'b0;
    cycle();
    chk("t5_rdata", 32'(rdata), 32'h00077);
    issue(1, 0, 7, 20'h0);
    cycle();
    do_reset();
    chk("t5_rst_rdata", 32'(rdata), 32'h0);
    cycle();
    chk("t5_no_rvalid", 32'(rvalid), 32'h0);

    bnd = '{0, 31, 32, 63};
    bval = '{20'h10000, 20'h2001F, 20'h30020, 20'h4003F};
    for (int i = 0; i < 4; i++) begin
      issue(i % 2, 1, bnd[i], bval[i]);
      cycle();
      req = '0;
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      issue((i + 1) % 2, 0, bnd[i], 20'h0);
      cycle();
      req = '0;
      cycle();
      chk("bnd_rdata", 32'(rdata), 32'(bval[i]));
    end

    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        for (int k = 0; k < 2; k++)
          if (!req[k] || m_gnt[k]) begin
            if ($urandom_range(0, 9) < 6)
              issue(k, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63)),
                    DATA_W'($urandom));
            else
              req[k] = 1'b0;
          end
        cycle();
      end
    end
    req = '0;
    cycle();
    cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
